timer_irq_ctrl: RTL and testbench

- Control stage directly downstream of the up/down counter. It drives the counter's enable/load/data inputs and consumes its count and overflow outputs.
- Turns the counter into a compare-match timer with one-shot and periodic modes, plus a level interrupt with acknowledge handshake.
- Sits between the CSR/peripheral write path and the CPU interrupt input.
- The counter is integrated in up mode (up0_down1=0, carry_in=0, Increment=1).

---
 rtl/timer_irq_ctrl.sv | 139 +++++++++++++
 tb/tb_timer_irq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_ctrl.sv
// Compare-match timer controller driving an up-counter: one-shot/periodic modes,
// level irq with ack, sticky missed/wrapped flags. Optional prescaler: TIMER_PRESCALE_EN.
module timer_irq_ctrl #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmp_we,
    input  logic             reload_we,
    input  logic [Width-1:0] wdata,
    input  logic             periodic,
    input  logic             arm,
    input  logic             disarm,
    input  logic             irq_ack,
    input  logic [Width-1:0] count,
    input  logic             overflow,
`ifdef TIMER_PRESCALE_EN
    input  logic [7:0]       prescale_div,
`endif
    output logic             cnt_enable,
    output logic             cnt_load,
    output logic [Width-1:0] cnt_data,
    output logic             irq,
    output logic             missed,
    output logic             wrapped,
    output logic             running
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [Width-1:0] cmp_q, cmp_d;
    logic [Width-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             irq_q, irq_d;
    logic             missed_q, missed_d;
    logic             wrapped_q, wrapped_d;

    logic tick;
    logic arm_go;
    logic match;

    // arm/disarm are single-cycle pulses; disarm wins a collision. irq is a level
    // that stays high until an irq_ack cycle with no new match.
    assign arm_go = arm & ~disarm;
    assign match  = (state_q == RUN) & tick & (count == cmp_q);

`ifdef TIMER_PRESCALE_EN
    logic [7:0] pre_q, pre_d;

    always_comb begin
        tick  = (pre_q == prescale_div);
        pre_d = '0;
        if (state_q == RUN && !arm_go) begin
            pre_d = tick ? 8'd0 : pre_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pre_q <= '0;
        else     pre_q <= pre_d;
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        cmp_d     = cmp_we ? wdata : cmp_q;
        reload_d  = reload_we ? wdata : reload_q;
        mode_d    = mode_q;
        irq_d     = irq_q;
        missed_d  = missed_q;
        wrapped_d = wrapped_q;

        case (state_q)
            IDLE: begin
                if (arm_go) begin
                    state_d = RUN;
                    mode_d  = periodic;
                end
            end
            RUN: begin
                if (disarm) begin
                    state_d = IDLE;
                end else if (arm_go) begin
                    mode_d = periodic;
                end else if (match && !mode_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new match overrides a same-cycle ack so the event is not lost.
        if (match)        irq_d = 1'b1;
        else if (irq_ack) irq_d = 1'b0;

        if (arm_go)                         missed_d = 1'b0;
        else if (match && irq_q && !irq_ack) missed_d = 1'b1;

        if (arm_go)                                        wrapped_d = 1'b0;
        else if (overflow && state_q == RUN && !match)     wrapped_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cmp_q     <= '0;
            reload_q  <= '0;
            mode_q    <= 1'b0;
            irq_q     <= 1'b0;
            missed_q  <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmp_q     <= cmp_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            irq_q     <= irq_d;
            missed_q  <= missed_d;
            wrapped_q <= wrapped_d;
        end
    end

    // The counter gives load priority over enable, so a load restarts from reload.
    always_comb begin
        cnt_enable = 1'b0;
        if (state_q == RUN) cnt_enable = tick & ~(match & ~mode_q);
        cnt_load = ~rst & (arm_go | (match & mode_q));
        cnt_data = reload_q;
    end

    assign irq     = irq_q;
    assign missed  = missed_q;
    assign wrapped = wrapped_q;
    assign running = (state_q == RUN);

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl with a behavioural up-counter closing the loop.
module tb_timer_irq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmp_we = 1'b0, reload_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         periodic = 1'b0, arm = 1'b0, disarm = 1'b0, irq_ack = 1'b0;
    logic [W-1:0] count;
    logic         overflow;
    logic         cnt_enable, cnt_load, irq, missed, wrapped, running;
    logic [W-1:0] cnt_data;
`ifdef TIMER_PRESCALE_EN
    logic [7:0]   prescale_div = 8'd0;
`endif

    int checks = 0;
    int failures = 0;

    timer_irq_ctrl #(.Width(W)) dut (
        .clk(clk), .rst(rst), .cmp_we(cmp_we), .reload_we(reload_we), .wdata(wdata),
        .periodic(periodic), .arm(arm), .disarm(disarm), .irq_ack(irq_ack),
        .count(count), .overflow(overflow),
`ifdef TIMER_PRESCALE_EN
        .prescale_div(prescale_div),
`endif
        .cnt_enable(cnt_enable), .cnt_load(cnt_load), .cnt_data(cnt_data),
        .irq(irq), .missed(missed), .wrapped(wrapped), .running(running)
    );

    always #5 clk = ~clk;

    // Up-counter model: load beats enable, overflow flags the 255->0 step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             count <= '0;
        else if (cnt_load)   count <= cnt_data;
        else if (cnt_enable) count <= count + 8'd1;
    end
    assign overflow = cnt_enable & ~cnt_load & (count == 8'hFF);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic c, input logic r, input logic [W-1:0] d);
        cmp_we = c; reload_we = r; wdata = d;
        cyc();
        cmp_we = 1'b0; reload_we = 1'b0;
    endtask

    logic [W-1:0] per_cnt [7] = '{8'd2, 8'd3, 8'd4, 8'd2, 8'd3, 8'd4, 8'd2};
    logic         per_irq [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        // Reset state, with a stray arm that must not reach the counter
        arm = 1'b1;
        #1;
        chk("rst_load", cnt_load, 0);
        chk("rst_en", cnt_enable, 0);
        chk("rst_data", cnt_data, 0);
        chk("rst_irq", irq, 0);
        chk("rst_missed", missed, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_running", running, 0);
        arm = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Both strobes take wdata
        wr(1'b1, 1'b1, 8'd7);
        chk("both_we_data", cnt_data, 7);

        // One-shot: reload 0, cmp 5
        wr(1'b0, 1'b1, 8'd0);
        wr(1'b1, 1'b0, 8'd5);
        periodic = 1'b0; arm = 1'b1;
        #1;
        chk("os_arm_load", cnt_load, 1);
        chk("os_arm_en_idle", cnt_enable, 0);
        cyc();
        arm = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            chk("os_count", count, i - 1);
            chk("os_running", running, 1);
            chk("os_irq_low", irq, 0);
            if (i == 6) chk("os_match_en", cnt_enable, 0);
            cyc();
        end
        chk("os_irq", irq, 1);
        chk("os_stop", running, 0);
        chk("os_hold", count, 5);
        cyc();
        chk("os_hold2", count, 5);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        chk("os_ack", irq, 0);

        // Periodic with ack: reload 2, cmp 4, period 3
        wr(1'b0, 1'b1, 8'd2);
        wr(1'b1, 1'b0, 8'd4);
        periodic = 1'b1; arm = 1'b1;
        cyc();
        arm = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("per_count", count, per_cnt[i]);
            chk("per_irq", irq, per_irq[i]);
            irq_ack = per_irq[i];
            cyc();
        end
        irq_ack = 1'b0;
        chk("per_ack_clr", irq, 0);
        chk("per_missed", missed, 0);
        disarm = 1'b1;
        cyc();
        disarm = 1'b0;
        chk("per_disarm", running, 0);

        // Missed event: reload 0, cmp 1, periodic, no ack
        wr(1'b0, 1'b1, 8'd0);
        wr(1'b1, 1'b0, 8'd1);
        periodic = 1'b1; arm = 1'b1;
        cyc();
        arm = 1'b0;
        chk("mis_c1", count, 0);
        cyc();
        chk("mis_c2", count, 1);
        chk("mis_reload", cnt_load, 1);
        cyc();
        chk("mis_irq1", irq, 1);
        chk("mis_m0", missed, 0);
        cyc();
        cyc();
        chk("mis_m1", missed, 1);
        chk("mis_irq2", irq, 1);
        cyc();
        chk("mis_c6", count, 1);
        irq_ack = 1'b1;
        cyc();
        chk("mis_ack_match", irq, 1);
        chk("mis_m_keep", missed, 1);
        cyc();
        irq_ack = 1'b0;
        chk("mis_ack_clr", irq, 0);
        cyc();
        chk("mis_rearm_irq", irq, 1);

        // Arm and disarm collision on a non-match cycle
        chk("col_pre_count", count, 0);
        arm = 1'b1; disarm = 1'b1;
        #1;
        chk("col_load", cnt_load, 0);
        cyc();
        arm = 1'b0; disarm = 1'b0;
        chk("col_idle", running, 0);
        chk("col_en", cnt_enable, 0);
        chk("col_irq", irq, 1);
        chk("col_missed", missed, 1);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;

        // Wrap: reload 4, cmp 3, one-shot
        wr(1'b0, 1'b1, 8'd4);
        wr(1'b1, 1'b0, 8'd3);
        periodic = 1'b0; arm = 1'b1;
        cyc();
        arm = 1'b0;
        chk("wr_start", count, 4);
        chk("wr_missed_clr", missed, 0);
        repeat (251) cyc();
        chk("wr_255", count, 8'hFF);
        chk("wr_ovf", overflow, 1);
        chk("wr_pre", wrapped, 0);
        cyc();
        chk("wr_zero", count, 0);
        chk("wr_flag", wrapped, 1);
        repeat (3) cyc();
        chk("wr_c3", count, 3);
        chk("wr_irq_low", irq, 0);
        cyc();
        chk("wr_irq", irq, 1);
        chk("wr_stop", running, 0);
        chk("wr_keep", wrapped, 1);
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        chk("wr_rearm_clr", wrapped, 0);
        chk("wr_rearm_run", running, 1);
        chk("wr_rearm_cnt", count, 4);

        // Reset mid-run with irq pending
        chk("rr_irq_pre", irq, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rr_irq", irq, 0);
        chk("rr_running", running, 0);
        chk("rr_en", cnt_enable, 0);
        chk("rr_load", cnt_load, 0);
        chk("rr_data", cnt_data, 0);
        chk("rr_wrapped", wrapped, 0);
        cyc();
        rst = 1'b0;
        cyc(); cyc();
        chk("rr_idle", running, 0);
        chk("rr_irq_post", irq, 0);
        chk("rr_en_post", cnt_enable, 0);

`ifdef TIMER_PRESCALE_EN
        // Prescale 2, reload 0, cmp 1, periodic: irq every 6 cycles
        prescale_div = 8'd2;
        wr(1'b0, 1'b1, 8'd0);
        wr(1'b1, 1'b0, 8'd1);
        periodic = 1'b1; arm = 1'b1;
        cyc();
        arm = 1'b0;
        repeat (5) cyc();
        chk("ps_c6_low", irq, 0);
        cyc();
        chk("ps_c7_irq", irq, 1);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        repeat (4) cyc();
        chk("ps_c12_low", irq, 0);
        cyc();
        chk("ps_c13_irq", irq, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
